// File: rtl/reg_file_param.sv
// reg_file_param: WIDTH x DEPTH register file with two combinational read ports,
// one write port and a one-register-per-cycle clear sweep. Define RF_BYPASS_EN for write-through forwarding.
module reg_file_param #(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b,
  input  logic              clr,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_in_range;
  logic              wr_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // busy decodes the state flop only, so no input reaches it combinationally
  assign busy = (state == CLEAR);

  // Addresses are matched against each implemented slot, so codes >= DEPTH hit nothing
  always_comb begin
    wr_in_range = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_in_range = 1'b1;
    end
  end

  assign wr_acc = wr && !reset && (state == IDLE) && wr_in_range;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        mem[i] <= '0;
      end else if (state == CLEAR) begin
        if (ptr == ADDR_W'(i)) mem[i] <= '0;
      end else if (wr_acc && (wr_addr == ADDR_W'(i))) begin
        mem[i] <= d_in;
      end
    end
  end

  always_comb begin
    d_out_a = '0;
    d_out_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == ADDR_W'(i)) d_out_a = mem[i];
      if (rd_addr_b == ADDR_W'(i)) d_out_b = mem[i];
    end
`ifdef RF_BYPASS_EN
    if (wr_acc && (rd_addr_a == wr_addr)) d_out_a = d_in;
    if (wr_acc && (rd_addr_b == wr_addr)) d_out_b = d_in;
`endif
  end

endmodule
